// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for the five-stage pipeline: branch flush, load-use stall
// and multi-cycle multiply/divide hold, plus stall/flush statistics.
module pipeline_hazard_ctrl #(
    parameter int MD_LATENCY = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  RsAddr_ID,
    input  logic [4:0]  RtAddr_ID,
    input  logic [4:0]  RtAddr_EX,
    input  logic        MemRead_EX,
    input  logic        MdStart_EX,
    input  logic        BranchTaken_EX,
    input  logic        StatClr,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IDEXWrite,
    output logic        IFIDFlush,
    output logic        IDEXFlush,
    output logic        MdDone,
    output logic [15:0] StallCnt,
    output logic [15:0] FlushCnt
);

    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] MD_WAIT = 2'd1;
    localparam logic [1:0] MD_DONE = 2'd2;

    // The start cycle and the final zero-count cycle are both stall cycles.
    localparam logic [4:0] MD_LOAD = 5'(MD_LATENCY - 2);

    logic [1:0]  state_q, state_d;
    logic [4:0]  md_cnt_q, md_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        load_use;

    assign load_use = MemRead_EX && (RtAddr_EX != 5'd0) &&
                      ((RtAddr_EX == RsAddr_ID) || (RtAddr_EX == RtAddr_ID));

    always_comb begin
        state_d   = state_q;
        md_cnt_d  = md_cnt_q;
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IDEXWrite = 1'b1;
        IFIDFlush = 1'b0;
        IDEXFlush = 1'b0;
        MdDone    = 1'b0;
        unique case (state_q)
            RUN: begin
                if (BranchTaken_EX) begin
                    IFIDFlush = 1'b1;
                    IDEXFlush = 1'b1;
                end else if (MdStart_EX) begin
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    IDEXWrite = 1'b0;
                    md_cnt_d  = MD_LOAD;
                    state_d   = MD_WAIT;
                end else if (load_use) begin
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    IDEXFlush = 1'b1;
                end
            end
            MD_WAIT: begin
                PCWrite   = 1'b0;
                IFIDWrite = 1'b0;
                IDEXWrite = 1'b0;
                if (md_cnt_q == 5'd0) begin
                    state_d = MD_DONE;
                end else begin
                    md_cnt_d = md_cnt_q - 5'd1;
                end
            end
            MD_DONE: begin
                MdDone  = 1'b1;
                state_d = RUN;
            end
            default: begin
                state_d  = RUN;
                md_cnt_d = 5'd0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StatClr) begin
            stall_cnt_d = 16'd0;
            flush_cnt_d = 16'd0;
        end else begin
            if (!PCWrite && (stall_cnt_q != 16'hFFFF))
                stall_cnt_d = stall_cnt_q + 16'd1;
            if (IFIDFlush && (flush_cnt_q != 16'hFFFF))
                flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            md_cnt_q    <= 5'd0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed bench for pipeline_hazard_ctrl against a
// cycle-count reference model.
module tb_pipeline_hazard_ctrl;

    localparam int L = 8;

    logic        clk;
    logic        rst_n;
    logic [4:0]  RsAddr_ID, RtAddr_ID, RtAddr_EX;
    logic        MemRead_EX, MdStart_EX, BranchTaken_EX, StatClr;
    logic        PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXFlush, MdDone;
    logic [15:0] StallCnt, FlushCnt;

    int n_checks = 0;
    int n_errors = 0;

    int m_left;
    bit m_done;
    int m_stall;
    int m_flush;

    pipeline_hazard_ctrl #(.MD_LATENCY(L)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .RsAddr_ID(RsAddr_ID),
        .RtAddr_ID(RtAddr_ID),
        .RtAddr_EX(RtAddr_EX),
        .MemRead_EX(MemRead_EX),
        .MdStart_EX(MdStart_EX),
        .BranchTaken_EX(BranchTaken_EX),
        .StatClr(StatClr),
        .PCWrite(PCWrite),
        .IFIDWrite(IFIDWrite),
        .IDEXWrite(IDEXWrite),
        .IFIDFlush(IFIDFlush),
        .IDEXFlush(IDEXFlush),
        .MdDone(MdDone),
        .StallCnt(StallCnt),
        .FlushCnt(FlushCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_left  = 0;
        m_done  = 1'b0;
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic step(input logic br, input logic ms, input logic mr,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rte, input logic clr,
                        input bit do_chk);
        logic e_pc, e_ifid, e_idex, e_iff, e_idf, e_done, lu;
        @(negedge clk);
        BranchTaken_EX = br;
        MdStart_EX     = ms;
        MemRead_EX     = mr;
        RsAddr_ID      = rs;
        RtAddr_ID      = rt;
        RtAddr_EX      = rte;
        StatClr        = clr;
        #1;
        lu = mr && (rte != 0) && (rte == rs || rte == rt);
        {e_pc, e_ifid, e_idex, e_iff, e_idf, e_done} = 6'b111000;
        if (m_done) e_done = 1'b1;
        else if (m_left > 0) {e_pc, e_ifid, e_idex} = 3'b000;
        else if (br) {e_iff, e_idf} = 2'b11;
        else if (ms) {e_pc, e_ifid, e_idex} = 3'b000;
        else if (lu) {e_pc, e_ifid, e_idf} = 3'b001;
        if (do_chk) begin
            chk("PCWrite", 32'(PCWrite), 32'(e_pc));
            chk("IFIDWrite", 32'(IFIDWrite), 32'(e_ifid));
            chk("IDEXWrite", 32'(IDEXWrite), 32'(e_idex));
            chk("IFIDFlush", 32'(IFIDFlush), 32'(e_iff));
            chk("IDEXFlush", 32'(IDEXFlush), 32'(e_idf));
            chk("MdDone", 32'(MdDone), 32'(e_done));
            chk("StallCnt", 32'(StallCnt), 32'(m_stall));
            chk("FlushCnt", 32'(FlushCnt), 32'(m_flush));
        end
        @(posedge clk);
        if (clr) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (!e_pc && m_stall < 65535) m_stall++;
            if (e_iff && m_flush < 65535) m_flush++;
        end
        if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end else if (!br && ms) begin
            m_left = L - 1;
        end
    endtask

    task automatic idle(input bit do_chk);
        step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, do_chk);
    endtask

    initial begin
        rst_n = 1'b0;
        {BranchTaken_EX, MdStart_EX, MemRead_EX, StatClr} = 4'b0;
        RsAddr_ID = 0;
        RtAddr_ID = 0;
        RtAddr_EX = 0;
        model_reset();
        #1;
        chk("rst_pc", 32'(PCWrite), 32'd1);
        chk("rst_stall", 32'(StallCnt), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        idle(1);
        step(0, 0, 1, 5'd5, 5'd1, 5'd5, 0, 1);
        #1 chk("lu_stall1", 32'(StallCnt), 32'd1);
        step(0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 1);
        chk("zero_reg_pc", 32'(PCWrite), 32'd1);

        step(0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 1);
        repeat (8) idle(1);
        step(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1);
        repeat (L + 2) idle(1);
        chk("md_stall8", 32'(StallCnt), 32'd8);

        step(0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 1);
        step(1, 0, 1, 5'd7, 5'd0, 5'd7, 0, 1);
        #1 chk("br_flush1", 32'(FlushCnt), 32'd1);
        chk("br_stall0", 32'(StallCnt), 32'd0);

        step(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1);
        repeat (3) idle(1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_md_pc", 32'(PCWrite), 32'd1);
        chk("rst_md_done", 32'(MdDone), 32'd0);
        chk("rst_md_stall", 32'(StallCnt), 32'd0);
        chk("rst_md_flush", 32'(FlushCnt), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (L + 2) idle(1);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                 1'($urandom), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 63) == 0), 1);
        end

        for (int i = 0; i < 65540; i++)
            step(0, 0, 1, 5'd9, 5'd0, 5'd9, 0, 0);
        #1 chk("stall_sat", 32'(StallCnt), 32'hFFFF);
        step(0, 0, 1, 5'd9, 5'd0, 5'd9, 0, 1);
        step(0, 0, 1, 5'd9, 5'd0, 5'd9, 1, 1);
        #1 chk("clr_prio", 32'(StallCnt), 32'd0);
        idle(1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter: MD_LATENCY, default 8, total EX-stage cycles of a multiply/divide op; legal range 2..32.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: RsAddr_ID  input  5  Rs field of the instruction in ID.
REQ-005 SHALL have port: RtAddr_ID  input  5  Rt field of the instruction in ID.
REQ-006 SHALL have port: RtAddr_EX  input  5  destination register of the instruction in EX.
REQ-007 SHALL have port: MemRead_EX  input  1  instruction in EX is a load.
REQ-008 SHALL have port: MdStart_EX  input  1  instruction in EX is a multiply/divide.
REQ-009 SHALL have port: BranchTaken_EX  input  1  branch in EX resolved taken.
REQ-010 SHALL have port: StatClr  input  1  synchronous clear of statistics counters.
REQ-011 SHALL have port: PCWrite  output  1  PC update enable.
REQ-012 SHALL have port: IFIDWrite  output  1  IF/ID register update enable.
REQ-013 SHALL have port: IDEXWrite  output  1  ID/EX register update enable (0 holds EX).
REQ-014 SHALL have port: IFIDFlush  output  1  zero IF/ID on next edge.
REQ-015 SHALL have port: IDEXFlush  output  1  insert bubble into ID/EX on next edge.
REQ-016 SHALL have port: MdDone  output  1  one-cycle pulse, mul/div result valid in EX.
REQ-017 SHALL have port: StallCnt  output  16  saturating count of cycles with PCWrite=0.
REQ-018 SHALL have port: FlushCnt  output  16  saturating count of cycles with IFIDFlush=1.

Function
REQ-019 SHALL implement FSM states RUN, MD_WAIT, MD_DONE, plus down-counter md_cnt of 5 bits.
REQ-020 SHALL, in RUN with no event: PCWrite=IFIDWrite=IDEXWrite=1, IFIDFlush=IDEXFlush=MdDone=0.
REQ-021 SHALL evaluate RUN events in priority: BranchTaken_EX > MdStart_EX > load-use.
REQ-022 SHALL, on RUN and BranchTaken_EX=1: IFIDFlush=1, IDEXFlush=1, write enables 1; stay RUN.
REQ-023 SHALL, on RUN and MdStart_EX=1 (no branch): PCWrite=IFIDWrite=IDEXWrite=0; load md_cnt=MD_LATENCY-2; go MD_WAIT.
REQ-024 SHALL detect load-use as MemRead_EX=1 and RtAddr_EX!=0 and (RtAddr_EX==RsAddr_ID or RtAddr_EX==RtAddr_ID).
REQ-025 SHALL, on load-use in RUN: PCWrite=0, IFIDWrite=0, IDEXWrite=1, IDEXFlush=1 for that cycle only; stay RUN.
REQ-026 SHALL, in MD_WAIT: PCWrite=IFIDWrite=IDEXWrite=0, flushes 0; BranchTaken_EX, MemRead_EX, MdStart_EX ignored.
REQ-027 SHALL, in MD_WAIT: if md_cnt==0 go MD_DONE, else decrement md_cnt.
REQ-028 SHALL, in MD_DONE: MdDone=1, write enables 1, flushes 0; go RUN unconditionally.
REQ-029 SHALL give latency: MdStart_EX seen in RUN at cycle T -> PCWrite=0 for cycles T..T+MD_LATENCY-1, MdDone=1 at T+MD_LATENCY only.
REQ-030 SHALL generate all outputs combinationally from state, md_cnt and inputs; only state, md_cnt, counters registered.
REQ-031 SHALL increment StallCnt each edge where PCWrite=0 and FlushCnt each edge where IFIDFlush=1; hold at 16'hFFFF.
REQ-032 SHALL give StatClr priority over increment: both counters become 0 on that edge.

Reset
REQ-033 SHALL, while rst_n=0, force state=RUN, md_cnt=0, StallCnt=0, FlushCnt=0 immediately, independent of clk.
REQ-034 SHALL abort any MD_WAIT/MD_DONE sequence on reset without emitting MdDone; outputs then follow REQ-020 given idle inputs.
REQ-035 SHALL resume evaluation on the first rising clk after rst_n deasserts.

Verification
REQ-036 SHALL cover: MemRead_EX=1, RtAddr_EX=5, RsAddr_ID=5 for 1 cycle -> PCWrite=0, IFIDWrite=0, IDEXFlush=1 that cycle; StallCnt=1.
REQ-037 SHALL cover: MemRead_EX=1, RtAddr_EX=0, RtAddr_ID=0 -> no stall, all write enables 1.
REQ-038 SHALL cover: MD_LATENCY=8, MdStart_EX pulse at cycle 10 -> PCWrite=0 cycles 10..17, MdDone=1 at cycle 18 only, StallCnt=8.
REQ-039 SHALL cover: BranchTaken_EX=1 with simultaneous load-use match -> IFIDFlush=IDEXFlush=1, PCWrite=1; FlushCnt=1, StallCnt unchanged.
REQ-040 SHALL cover: rst_n low at cycle 3 of MD_WAIT -> state RUN, no MdDone pulse, counters 0; StallCnt forced past 65535 stall cycles holds 16'hFFFF; StatClr with stall same cycle -> 0.
